// File: rtl/uart_receiver_if.sv
// ----------------------------------------------------------------------------
// uart_receiver_if
//   Groups the UART receive path signals between the serial front end, the
//   receiver and the byte consumer.
//
//   Select    [2:0] baud select (divisor table index)
//   Rx              serial line, idles high, asynchronous to the clock
//   Data      [7:0] last received byte
//   Valid           one-cycle pulse, Data holds a good frame
//   FrameErr        one-cycle pulse, stop bit sampled low
//   ParityErr       one-cycle pulse, parity mismatch
//   Busy            receiver is inside a frame
//
//   master : the receiver (consumes Select/Rx, produces the byte stream)
//   slave  : the line driver / byte consumer side
// ----------------------------------------------------------------------------
interface uart_receiver_if;
    logic [2:0] Select;
    logic       Rx;
    logic [7:0] Data;
    logic       Valid;
    logic       FrameErr;
    logic       ParityErr;
    logic       Busy;

    modport master (
        input  Select,
        input  Rx,
        output Data,
        output Valid,
        output FrameErr,
        output ParityErr,
        output Busy
    );

    modport slave (
        output Select,
        output Rx,
        input  Data,
        input  Valid,
        input  FrameErr,
        input  ParityErr,
        input  Busy
    );
endinterface

// File: rtl/uart_receiver.sv
// ----------------------------------------------------------------------------
// uart_receiver
//   Recovers 8-bit UART frames (LSB first, optional parity, one stop bit)
//   from the asynchronous Rx line. A private bit-period counter is re-aligned
//   on every start-bit falling edge and samples each bit at its middle, using
//   the same Select divisor table as the baud tick generator.
//
//   Parameters
//     PARITY : 0 = none (8N1), 1 = even (8E1), 2 = odd (8O1)
//
//   Ports
//     Clk        system clock, rising edge
//     Rst        asynchronous reset, active low
//     bus.Select baud select, latched at the start edge of each frame
//     bus.Rx     serial input
//     bus.Data   last completed frame (good or bad)
//     bus.Valid / bus.FrameErr / bus.ParityErr  one-cycle result pulses
//     bus.Busy   high from the clock after start-edge detection until the
//                receiver returns to IDLE
// ----------------------------------------------------------------------------
module uart_receiver #(
    parameter int PARITY = 0
) (
    input  logic             Clk,
    input  logic             Rst,
    uart_receiver_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    function automatic logic [31:0] div_lookup(input logic [2:0] sel);
        logic [31:0] d;
        case (sel)
            3'b000:  d = 32'd300;
            3'b001:  d = 32'd20833;
            3'b010:  d = 32'd10416;
            3'b011:  d = 32'd5208;
            3'b100:  d = 32'd2604;
            3'b101:  d = 32'd200;
            3'b110:  d = 32'd868;
            default: d = 32'd100;
        endcase
        return d;
    endfunction

    // Even parity: the data bits plus the parity bit must hold an even number
    // of ones; odd parity the reverse.
    function automatic logic parity_error(input logic [7:0] d, input logic b);
        logic x;
        x = ^{d, b};
        if (PARITY == 1)
            return x;
        else if (PARITY == 2)
            return ~x;
        else
            return 1'b0;
    endfunction

    state_t      state, state_nxt;
    logic        rx_p0, rx_s, rx_prev;
    logic [31:0] cnt, cnt_nxt;
    logic [31:0] div_q, div_nxt;
    logic [31:0] div_new;
    logic [7:0]  sh, sh_nxt;
    logic [2:0]  idx, idx_nxt;
    logic        perr_q, perr_nxt;
    logic [7:0]  data_q, data_nxt;
    logic        valid_q, valid_nxt;
    logic        ferr_q, ferr_nxt;
    logic        perr_pulse_q, perr_pulse_nxt;
    logic        fall;
    logic        sample;

    // Falling edge seen on the synchronized line.
    assign fall   = rx_prev & ~rx_s;
    // The sample event: the counter has reached zero.
    assign sample = (cnt == 32'd0);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = (cnt != 32'd0) ? cnt - 32'd1 : cnt;
        div_nxt        = div_q;
        sh_nxt         = sh;
        idx_nxt        = idx;
        perr_nxt       = perr_q;
        data_nxt       = data_q;
        valid_nxt      = 1'b0;
        ferr_nxt       = 1'b0;
        perr_pulse_nxt = 1'b0;
        div_new        = div_lookup(bus.Select);

        case (state)
            IDLE: begin
                if (fall) begin
                    div_nxt   = div_new;
                    // Half a bit period counted from the clock rx_s first
                    // read 0; that clock has already elapsed by the time the
                    // counter is loaded, hence the -1.
                    cnt_nxt   = ((div_new + 32'd1) >> 1) - 32'd1;
                    idx_nxt   = 3'd0;
                    perr_nxt  = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (sample) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = div_q;
                        idx_nxt   = 3'd0;
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    sh_nxt  = {rx_s, sh[7:1]};
                    cnt_nxt = div_q;
                    idx_nxt = idx + 3'd1;
                    if (idx == 3'd7)
                        state_nxt = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                if (sample) begin
                    perr_nxt  = parity_error(sh, rx_s);
                    cnt_nxt   = div_q;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    data_nxt       = sh;
                    ferr_nxt       = ~rx_s;
                    perr_pulse_nxt = perr_q;
                    valid_nxt      = rx_s & ~perr_q;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rx_p0        <= 1'b1;
            rx_s         <= 1'b1;
            rx_prev      <= 1'b1;
            cnt          <= 32'd0;
            div_q        <= 32'd0;
            sh           <= 8'h00;
            idx          <= 3'd0;
            perr_q       <= 1'b0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
            perr_pulse_q <= 1'b0;
        end else begin
            rx_p0        <= bus.Rx;
            rx_s         <= rx_p0;
            rx_prev      <= rx_s;
            cnt          <= cnt_nxt;
            div_q        <= div_nxt;
            sh           <= sh_nxt;
            idx          <= idx_nxt;
            perr_q       <= perr_nxt;
            data_q       <= data_nxt;
            valid_q      <= valid_nxt;
            ferr_q       <= ferr_nxt;
            perr_pulse_q <= perr_pulse_nxt;
        end
    end

    assign bus.Data      = data_q;
    assign bus.Valid     = valid_q;
    assign bus.FrameErr  = ferr_q;
    assign bus.ParityErr = perr_pulse_q;
    assign bus.Busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// ----------------------------------------------------------------------------
// tb_uart_receiver
//   Drives UART frames into two receivers (no parity and even parity) and
//   checks every result pulse against a frame-level reference model.
// ----------------------------------------------------------------------------
module tb_uart_receiver;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    uart_receiver_if bus0 ();
    uart_receiver_if bus1 ();

    uart_receiver #(.PARITY(0)) dut0 (.Clk(Clk), .Rst(Rst), .bus(bus0));
    uart_receiver #(.PARITY(1)) dut1 (.Clk(Clk), .Rst(Rst), .bus(bus1));

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       fe;
        logic       pe;
        logic       b;
        int         lat;
    } ev_t;

    ev_t  obs0[$];
    ev_t  obs1[$];
    ev_t  exp0[$];
    ev_t  exp1[$];

    int   cyc        = 0;
    int   busy_rise0 = 0;
    int   busy_fall0 = 0;
    int   busy_rise1 = 0;
    int   rises0     = 0;
    logic busy_d0    = 1'b0;
    logic busy_d1    = 1'b0;

    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Collect every result pulse together with its distance from Busy rising.
    always @(negedge Clk) begin
        busy_d0 <= bus0.Busy;
        busy_d1 <= bus1.Busy;
        if (bus0.Busy && !busy_d0) begin
            busy_rise0 <= cyc;
            rises0     <= rises0 + 1;
        end
        if (!bus0.Busy && busy_d0) busy_fall0 <= cyc;
        if (bus1.Busy && !busy_d1) busy_rise1 <= cyc;
        if (bus0.Valid || bus0.FrameErr || bus0.ParityErr)
            obs0.push_back('{d: bus0.Data, v: bus0.Valid, fe: bus0.FrameErr,
                             pe: bus0.ParityErr, b: bus0.Busy, lat: cyc - busy_rise0});
        if (bus1.Valid || bus1.FrameErr || bus1.ParityErr)
            obs1.push_back('{d: bus1.Data, v: bus1.Valid, fe: bus1.FrameErr,
                             pe: bus1.ParityErr, b: bus1.Busy, lat: cyc - busy_rise1});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int div_of(input logic [2:0] s);
        case (s)
            3'd0:    return 300;
            3'd1:    return 20833;
            3'd2:    return 10416;
            3'd3:    return 5208;
            3'd4:    return 2604;
            3'd5:    return 200;
            3'd6:    return 868;
            default: return 100;
        endcase
    endfunction

    // Reference model: what a receiver must report for one frame on the wire.
    task automatic expect_frame(input int u, input logic [7:0] b, input bit pbit,
                                input bit stop, input logic [2:0] sel);
        ev_t e;
        int  p;
        bit  perr;
        p    = div_of(sel) + 1;
        perr = (u == 1) && ((($countones(b) + int'(pbit)) % 2) != 0);
        e.d   = b;
        e.fe  = !stop;
        e.pe  = perr;
        e.v   = stop && !perr;
        e.b   = 1'b0;
        e.lat = 9 * p + (p >> 1) + ((u == 1) ? p : 0);
        if (u == 0) exp0.push_back(e); else exp1.push_back(e);
    endtask

    task automatic set_rx(input int u, input logic v);
        if (u == 0) bus0.Rx = v; else bus1.Rx = v;
    endtask

    task automatic set_sel(input logic [2:0] s);
        bus0.Select = s;
        bus1.Select = s;
    endtask

    // Transmit one frame at 'per' clocks per bit. rst_at > 0 asserts Rst at that
    // clock of the frame and holds it to the end; sel_at > 0 changes Select.
    task automatic send_frame(input int u, input logic [7:0] b, input int per,
                              input bit pbit, input bit stop,
                              input int rst_at, input int sel_at);
        logic [10:0] bits;
        int          nb;
        int          k;
        k    = 0;
        bits = '0;
        bits[8:1] = b;
        if (u == 1) begin
            bits[9]  = pbit;
            bits[10] = stop;
            nb = 11;
        end else begin
            bits[9] = stop;
            nb = 10;
        end
        for (int i = 0; i < nb; i++) begin
            set_rx(u, bits[i]);
            for (int c = 0; c < per; c++) begin
                @(negedge Clk);
                k++;
                if (k == rst_at) Rst = 1'b0;
                if (rst_at > 0 && k == rst_at + 3)
                    chk("rst_outputs", {bus0.Data, bus0.Valid, bus0.FrameErr,
                                        bus0.ParityErr, bus0.Busy}, 64'd0);
                if (k == sel_at) set_sel(3'b000);
            end
        end
        if (rst_at > 0) Rst = 1'b1;
    endtask

    task automatic settle(input int u);
        int n;
        n = 0;
        while (((u == 0) ? bus0.Busy : bus1.Busy) && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        chk("settle_in_time", (n < 3000), 1);
        repeat (4) @(negedge Clk);
    endtask

    task automatic compare_events(input string tag, input ev_t o[$], input ev_t e[$]);
        int n;
        chk({tag, "_count"}, o.size(), e.size());
        n = (o.size() < e.size()) ? o.size() : e.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, o[i].d, e[i].d);
            chk({tag, "_flags_vfpb"}, {o[i].v, o[i].fe, o[i].pe, o[i].b},
                                      {e[i].v, e[i].fe, e[i].pe, e[i].b});
            chk({tag, "_latency"}, o[i].lat, e[i].lat);
        end
    endtask

    initial begin
        logic [7:0] bytes4 [4];
        logic [7:0] b;
        int         r;
        int         w;
        int         per;
        int         gap;
        bit         stop;
        bit         pbit;

        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bytes4 [4];
        logic [7:0] b;
        int         r;
        int         w;
        int         per;
        int         gap;
        bit         stop;
        bit         pbit;

        bus0.Rx = 1'b1;
        bus1.Rx = 1'b1;
        set_sel(3'b111);
        Rst = 1'b0;
        repeat (5) @(negedge Clk);
        chk("reset_dut0", {bus0.Data, bus0.Valid, bus0.FrameErr, bus0.ParityErr, bus0.Busy}, 64'd0);
        chk("reset_dut1", {bus1.Data, bus1.Valid, bus1.FrameErr, bus1.ParityErr, bus1.Busy}, 64'd0);
        Rst = 1'b1;
        repeat (10) @(negedge Clk);

        // 0xA5 then 0x00, 0xFF, 0x3C with no idle gap
        bytes4[0] = 8'hA5; bytes4[1] = 8'h00; bytes4[2] = 8'hFF; bytes4[3] = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            expect_frame(0, bytes4[i], 1'b0, 1'b1, 3'b111);
            send_frame(0, bytes4[i], 101, 1'b0, 1'b1, -1, -1);
        end
        settle(0);
        compare_events("b2b", obs0, exp0);
        obs0.delete(); exp0.delete();

        // transmitter period mismatch
        for (int j = 0; j < 2; j++) begin
            per = (j == 0) ? 97 : 105;
            expect_frame(0, 8'h5A, 1'b0, 1'b1, 3'b111);
            send_frame(0, 8'h5A, per, 1'b0, 1'b1, -1, -1);
            expect_frame(0, 8'h81, 1'b0, 1'b1, 3'b111);
            send_frame(0, 8'h81, per, 1'b0, 1'b1, -1, -1);
        end
        settle(0);
        compare_events("skew", obs0, exp0);
        obs0.delete(); exp0.delete();

        // 20-clock low glitch: false start
        r = rises0;
        set_rx(0, 1'b0);
        repeat (20) @(negedge Clk);
        set_rx(0, 1'b1);
        repeat (200) @(negedge Clk);
        chk("glitch_busy_rises", rises0 - r, 1);
        w = busy_fall0 - busy_rise0;
        chk("glitch_busy_len_near_half_bit", (w >= 48 && w <= 52), 1);
        compare_events("glitch", obs0, exp0);
        obs0.delete(); exp0.delete();

        // frame error, line held low (break), then a good frame
        expect_frame(0, 8'h33, 1'b0, 1'b0, 3'b111);
        send_frame(0, 8'h33, 101, 1'b0, 1'b0, -1, -1);
        repeat (2) @(negedge Clk);
        r = rises0;
        repeat (500) @(negedge Clk);
        chk("break_no_retrigger", rises0 - r, 0);
        chk("break_busy", bus0.Busy, 0);
        set_rx(0, 1'b1);
        repeat (202) @(negedge Clk);
        expect_frame(0, 8'h77, 1'b0, 1'b1, 3'b111);
        send_frame(0, 8'h77, 101, 1'b0, 1'b1, -1, -1);
        settle(0);
        compare_events("break", obs0, exp0);
        obs0.delete(); exp0.delete();
        repeat (30) @(negedge Clk);
        chk("data_hold", bus0.Data, 8'h77);

        // even parity receiver
        expect_frame(1, 8'h07, 1'b1, 1'b1, 3'b111);
        send_frame(1, 8'h07, 101, 1'b1, 1'b1, -1, -1);
        expect_frame(1, 8'h07, 1'b0, 1'b1, 3'b111);
        send_frame(1, 8'h07, 101, 1'b0, 1'b1, -1, -1);
        settle(1);
        compare_events("parity", obs1, exp1);
        obs1.delete(); exp1.delete();

        // reset during data bit 4 of 0xC3, held until the frame has passed
        send_frame(0, 8'hC3, 101, 1'b0, 1'b1, 5 * 101 + 50, -1);
        repeat (20) @(negedge Clk);
        compare_events("abort", obs0, exp0);
        obs0.delete(); exp0.delete();

        // 0x96 with Select changed mid-frame: timing of this frame unchanged
        expect_frame(0, 8'h96, 1'b0, 1'b1, 3'b111);
        send_frame(0, 8'h96, 101, 1'b0, 1'b1, -1, 400);
        settle(0);
        set_sel(3'b111);
        compare_events("after_rst", obs0, exp0);
        obs0.delete(); exp0.delete();
        repeat (20) @(negedge Clk);

        // randomized frames, no-parity receiver
        for (int i = 0; i < 16; i++) begin
            b    = 8'($urandom_range(0, 255));
            per  = $urandom_range(97, 105);
            stop = ($urandom_range(0, 7) != 0);
            gap  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
            if (!stop && gap < 10) gap = 10;
            expect_frame(0, b, 1'b0, stop, 3'b111);
            send_frame(0, b, per, 1'b0, stop, -1, -1);
            set_rx(0, 1'b1);
            repeat (gap) @(negedge Clk);
        end
        settle(0);
        compare_events("rand0", obs0, exp0);
        obs0.delete(); exp0.delete();

        // randomized frames, even-parity receiver
        for (int i = 0; i < 10; i++) begin
            b    = 8'($urandom_range(0, 255));
            per  = $urandom_range(97, 105);
            pbit = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 5) != 0);
            gap  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
            if (!stop && gap < 10) gap = 10;
            expect_frame(1, b, pbit, stop, 3'b111);
            send_frame(1, b, per, pbit, stop, -1, -1);
            set_rx(1, 1'b1);
            repeat (gap) @(negedge Clk);
        end
        settle(1);
        compare_events("rand1", obs1, exp1);
        obs1.delete(); exp1.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
